// File: rtl/cache_ctrl_pkg.sv
// Shared types for the cache controller: state encoding, op encoding and
// the Moore output decode used to build the registered control outputs.
package cache_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, CWRITE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT,
        FILL_WR, MEM_REQ, MEM_WAIT, RESP
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef struct packed {
        logic rdy;
        logic w;
        logic wsel;
        logic dset;
        logic dclr;
        logic mstrobe;
        logic mrw;
        logic busy;
    } ctrl_out_t;

    // last: word counter of the given state is at the final word of the line
    function automatic ctrl_out_t decode_outputs(state_t s, logic op, logic last, logic wb);
        ctrl_out_t o;
        o      = '0;
        o.busy = (s != IDLE);
        case (s)
            CWRITE: begin
                o.w    = 1'b1;
                o.dset = wb;
            end
            WB_REQ, MEM_REQ: begin
                o.mstrobe = 1'b1;
                o.mrw     = 1'b1;
            end
            WB_WAIT, MEM_WAIT: o.mrw = 1'b1;
            FILL_REQ:          o.mstrobe = 1'b1;
            FILL_WR: begin
                o.w    = 1'b1;
                o.wsel = 1'b1;
                o.dclr = wb & last & (op == OP_READ);
            end
            RESP:    o.rdy = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing one memory access; done while the count is zero.
module mem_lat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (dec_i)
            cnt_q <= cnt_q - CNT_W'(1);
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Cache controller sequencing lookup, write-back, line fill and memory writes.
// All outputs are registered from the next state so they follow the state exactly.
module cache_ctrl_fsm
    import cache_ctrl_pkg::*;
#(
    parameter int MEM_LAT    = 4,
    parameter int LINE_WORDS = 4,
    parameter int WRITE_BACK = 0,
    localparam int WIDX_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Strobe,
    input  logic              RW,
    input  logic              M,
    input  logic              V,
    input  logic              D,
    output logic              Rdy,
    output logic              W,
    output logic              WSel,
    output logic              DSet,
    output logic              DClr,
    output logic              MStrobe,
    output logic              MRW,
    output logic [WIDX_W-1:0] WordIdx,
    output logic              Busy
);

    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(LINE_WORDS - 1);
    localparam logic [7:0]        LAT_LOAD  = 8'(MEM_LAT - 1);
    localparam logic              WB        = (WRITE_BACK != 0);

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic [WIDX_W-1:0] wcnt_q, wcnt_d;
    logic              cnt_load, cnt_dec, cnt_done;
    ctrl_out_t         out_q;
    logic [WIDX_W-1:0] widx_q;
    logic              hit, last_word;

    assign hit       = M & V;
    assign last_word = (wcnt_q == LAST_WORD);

    mem_lat_counter #(.CNT_W(8)) u_lat (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (LAT_LOAD),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        wcnt_d   = wcnt_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                if (Strobe) begin
                    op_d    = RW;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit && op_q == OP_READ)  state_d = RESP;
                else if (hit)                state_d = CWRITE;
                else if (!WB && op_q == OP_WRITE) state_d = MEM_REQ;
                else if (WB && V && D)       state_d = WB_REQ;
                else                         state_d = FILL_REQ;
            end
            CWRITE: state_d = WB ? RESP : MEM_REQ;
            MEM_REQ: begin
                cnt_load = 1'b1;
                state_d  = MEM_WAIT;
            end
            WB_REQ: begin
                cnt_load = 1'b1;
                state_d  = WB_WAIT;
            end
            FILL_REQ: begin
                cnt_load = 1'b1;
                state_d  = FILL_WAIT;
            end
            MEM_WAIT: begin
                if (cnt_done) state_d = RESP;
                else          cnt_dec = 1'b1;
            end
            WB_WAIT: begin
                if (!cnt_done) begin
                    cnt_dec = 1'b1;
                end else if (last_word) begin
                    wcnt_d  = '0;
                    state_d = FILL_REQ;
                end else begin
                    wcnt_d  = wcnt_q + WIDX_W'(1);
                    state_d = WB_REQ;
                end
            end
            FILL_WAIT: begin
                if (cnt_done) state_d = FILL_WR;
                else          cnt_dec = 1'b1;
            end
            FILL_WR: begin
                if (!last_word) begin
                    wcnt_d  = wcnt_q + WIDX_W'(1);
                    state_d = FILL_REQ;
                end else if (op_q == OP_READ) begin
                    state_d = RESP;
                end else begin
                    state_d = CWRITE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            wcnt_q  <= '0;
            out_q   <= '0;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wcnt_q  <= wcnt_d;
            out_q   <= decode_outputs(state_d, op_d, wcnt_d == LAST_WORD, WB);
            // word index is only meaningful on write-back and fill transfers
            widx_q  <= (state_d inside {WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, FILL_WR})
                       ? wcnt_d : '0;
        end
    end

    assign Rdy     = out_q.rdy;
    assign W       = out_q.w;
    assign WSel    = out_q.wsel;
    assign DSet    = out_q.dset;
    assign DClr    = out_q.dclr;
    assign MStrobe = out_q.mstrobe;
    assign MRW     = out_q.mrw;
    assign Busy    = out_q.busy;
    assign WordIdx = widx_q;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: two configurations, event-level reference model,
// directed vector table, random requests, reset-abort and held-strobe sequences.
module tb_cache_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst, stb, rw, m, v, dd;
    wire  [1:0] rdy, w, wsel, dset, dclr, mstb, mrw, busy;
    wire  [1:0] widx0;
    wire  [0:0] widx1;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];
    int obs_q[$];

    // dut0: defaults (write-through, 4 words, latency 4)
    cache_ctrl_fsm dut0 (
        .clk(clk), .reset(rst[0]), .Strobe(stb[0]), .RW(rw[0]), .M(m[0]), .V(v[0]), .D(dd[0]),
        .Rdy(rdy[0]), .W(w[0]), .WSel(wsel[0]), .DSet(dset[0]), .DClr(dclr[0]),
        .MStrobe(mstb[0]), .MRW(mrw[0]), .WordIdx(widx0), .Busy(busy[0])
    );

    // dut1: write-back, 2 words, latency 1
    cache_ctrl_fsm #(.MEM_LAT(1), .LINE_WORDS(2), .WRITE_BACK(1)) dut1 (
        .clk(clk), .reset(rst[1]), .Strobe(stb[1]), .RW(rw[1]), .M(m[1]), .V(v[1]), .D(dd[1]),
        .Rdy(rdy[1]), .W(w[1]), .WSel(wsel[1]), .DSet(dset[1]), .DClr(dclr[1]),
        .MStrobe(mstb[1]), .MRW(mrw[1]), .WordIdx(widx1), .Busy(busy[1])
    );

    localparam int K_MSTB = 1, K_WR = 2, K_DSET = 3, K_DCLR = 4, K_RDY = 5;

    function automatic int widx(input int d);
        return (d == 1) ? int'(widx1) : int'(widx0);
    endfunction

    function automatic int all_zero(input int d);
        return (rdy[d] | w[d] | wsel[d] | dset[d] | dclr[d] | mstb[d] | mrw[d] | busy[d]) == 1'b0
               && widx(d) == 0;
    endfunction

    function automatic int ev(input int c, input int k, input int f, input int x);
        return (c << 8) | (k << 5) | (f << 4) | x;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Expected event list built from the latency rules: each word costs
    // MEM_LAT+1 cycles to write back and MEM_LAT+2 cycles to fill.
    task automatic model(input int d, input bit r, input bit mm, input bit vv, input bit ddd);
        int lw, lat, c;
        bit wb, hit;
        wb  = (d == 1);
        lw  = (d == 1) ? 2 : 4;
        lat = (d == 1) ? 1 : 4;
        hit = mm & vv;
        exp_q.delete();
        if (!r && hit) begin
            exp_q.push_back(ev(2, K_RDY, 0, 0));
        end else if (!wb && r) begin
            c = 2;
            if (hit) begin
                exp_q.push_back(ev(2, K_WR, 0, 0));
                c = 3;
            end
            exp_q.push_back(ev(c, K_MSTB, 1, 0));
            exp_q.push_back(ev(c + lat + 1, K_RDY, 0, 0));
        end else if (wb && r && hit) begin
            exp_q.push_back(ev(2, K_WR, 0, 0));
            exp_q.push_back(ev(2, K_DSET, 0, 0));
            exp_q.push_back(ev(3, K_RDY, 0, 0));
        end else begin
            c = 2;
            if (wb && vv && ddd)
                for (int i = 0; i < lw; i++) begin
                    exp_q.push_back(ev(c, K_MSTB, 1, i));
                    c += lat + 1;
                end
            for (int i = 0; i < lw; i++) begin
                exp_q.push_back(ev(c, K_MSTB, 0, i));
                exp_q.push_back(ev(c + lat + 1, K_WR, 1, i));
                if (i == lw - 1 && wb && !r) exp_q.push_back(ev(c + lat + 1, K_DCLR, 0, 0));
                c += lat + 2;
            end
            if (r) begin
                exp_q.push_back(ev(c, K_WR, 0, 0));
                exp_q.push_back(ev(c, K_DSET, 0, 0));
                c++;
            end
            exp_q.push_back(ev(c, K_RDY, 0, 0));
        end
    endtask

    task automatic do_req(input int d, input bit r, input bit mm, input bit vv, input bit ddd,
                          output int rdy_c, output int n_m);
        bit done, busy_ok;
        int n;
        model(d, r, mm, vv, ddd);
        obs_q.delete();
        rdy_c = -1; n_m = 0; busy_ok = 1'b1; done = 1'b0;
        @(negedge clk);
        stb[d] = 1'b1; rw[d] = r; m[d] = mm; v[d] = vv; dd[d] = ddd;
        @(negedge clk);
        stb[d] = 1'b0;
        for (int k = 1; k <= 400 && !done; k++) begin
            if (!busy[d]) busy_ok = 1'b0;
            if (mstb[d]) begin
                obs_q.push_back(ev(k, K_MSTB, int'(mrw[d]), widx(d)));
                n_m++;
            end
            if (w[d])    obs_q.push_back(ev(k, K_WR, int'(wsel[d]), widx(d)));
            if (dset[d]) obs_q.push_back(ev(k, K_DSET, 0, 0));
            if (dclr[d]) obs_q.push_back(ev(k, K_DCLR, 0, 0));
            if (rdy[d]) begin
                obs_q.push_back(ev(k, K_RDY, 0, 0));
                rdy_c = k;
                done  = 1'b1;
            end
            if (!done) @(negedge clk);
        end
        check($sformatf("d%0d rdy_seen", d), int'(done), 1);
        check($sformatf("d%0d busy_during_req", d), int'(busy_ok), 1);
        check($sformatf("d%0d event_count", d), obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("d%0d event%0d(cyc<<8|kind<<5|flag<<4|widx)", d, i), obs_q[i], exp_q[i]);
        @(negedge clk);
        check($sformatf("d%0d idle_after_rdy", d), all_zero(d), 1);
    endtask

    typedef struct {
        int d;
        bit rw, m, v, dd;
        int exp_rdy;
        int exp_nmstb;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int rc, nm;
        vecs[0] = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 0};   // read hit
        vecs[1] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 26, 4};  // read miss, invalid line
        vecs[2] = '{0, 1'b1, 1'b1, 1'b1, 1'b0, 8, 1};   // write-through hit
        vecs[3] = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 7, 1};   // write-through miss
        vecs[4] = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 26, 4};  // dirty bit ignored
        vecs[5] = '{1, 1'b0, 1'b0, 1'b1, 1'b1, 12, 4};  // dirty read miss
        vecs[6] = '{1, 1'b0, 1'b0, 1'b0, 1'b1, 8, 2};   // clean read miss
        vecs[7] = '{1, 1'b1, 1'b1, 1'b1, 1'b0, 3, 0};   // write-back hit
        vecs[8] = '{1, 1'b1, 1'b0, 1'b1, 1'b1, 13, 4};  // dirty write miss
        vecs[9] = '{1, 1'b0, 1'b1, 1'b1, 1'b1, 2, 0};   // read hit on dirty line

        rst = 2'b11; stb = '0; rw = '0; m = '0; v = '0; dd = '0;
        repeat (3) @(negedge clk);
        check("d0 reset_outputs", all_zero(0), 1);
        check("d1 reset_outputs", all_zero(1), 1);
        rst = 2'b00;
        @(negedge clk);
        check("d0 post_reset_outputs", all_zero(0), 1);
        check("d1 post_reset_outputs", all_zero(1), 1);

        foreach (vecs[i]) begin
            do_req(vecs[i].d, vecs[i].rw, vecs[i].m, vecs[i].v, vecs[i].dd, rc, nm);
            check($sformatf("vec%0d rdy_cycle", i), rc, vecs[i].exp_rdy);
            check($sformatf("vec%0d mstrobe_count", i), nm, vecs[i].exp_nmstb);
        end

        for (int i = 0; i < 40; i++)
            do_req(int'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), rc, nm);

        // reset in the middle of a fill aborts it
        @(negedge clk);
        stb[0] = 1'b1; rw[0] = 1'b0; m[0] = 1'b0; v[0] = 1'b0;
        @(negedge clk);
        stb[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("abort busy_before_reset", int'(busy[0]), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        check("abort outputs_after_reset", all_zero(0), 1);
        rst[0] = 1'b0;
        begin
            int activity;
            activity = 0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (mstb[0] | w[0] | rdy[0] | busy[0]) activity++;
            end
            check("abort no_activity_after_reset", activity, 0);
        end

        // strobe held high: accepted only in IDLE, one request every 3 cycles
        @(negedge clk);
        stb[1] = 1'b1; rw[1] = 1'b0; m[1] = 1'b1; v[1] = 1'b1; dd[1] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            check($sformatf("held c%0d busy", c), int'(busy[1]), int'(c % 3 != 0));
            check($sformatf("held c%0d rdy", c), int'(rdy[1]), int'(c % 3 == 2));
            @(negedge clk);
        end
        stb[1] = 1'b0;
        repeat (4) @(negedge clk);
        check("held idle_at_end", all_zero(1), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_fsm.md
CACHE_CTRL_FSM -- requirements
Module: cache_ctrl_fsm

Interface
REQ-001 Parameter MEM_LAT, default 4: memory access latency in cycles; legal range 1..255.
REQ-002 Parameter LINE_WORDS, default 4: words per cache line; legal values are powers of two, 1..64.
REQ-003 Parameter WRITE_BACK, default 0: 0 selects write-through/no-allocate; 1 selects write-back/write-allocate.
REQ-004 Derived constant WIDX_W = max(1, clog2(LINE_WORDS)).
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 Strobe  in  1  CPU request valid.
REQ-008 RW  in  1  request type: 1 = write, 0 = read.
REQ-009 M  in  1  tag match for the indexed line.
REQ-010 V  in  1  valid bit of the indexed line.
REQ-011 D  in  1  dirty bit of the indexed line; ignored when WRITE_BACK=0.
REQ-012 Rdy  out  1  one-cycle request completion pulse.
REQ-013 W  out  1  cache data/tag array write enable.
REQ-014 WSel  out  1  cache write source: 1 = memory data, 0 = CPU data.
REQ-015 DSet / DClr  out  1 each  set or clear the dirty bit of the indexed line.
REQ-016 MStrobe  out  1  one-cycle memory request pulse.
REQ-017 MRW  out  1  memory direction: 1 = write, 0 = read.
REQ-018 WordIdx  out  WIDX_W  word-within-line index for the current memory or fill access.
REQ-019 Busy  out  1  high in every state except IDLE.

Function
REQ-020 States: IDLE, LOOKUP, CWRITE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, FILL_WR, MEM_REQ, MEM_WAIT, RESP. All outputs are Moore outputs.
REQ-021 IDLE with Strobe=1: latch RW into the operation register and go to LOOKUP. Strobe is ignored in every other state.
REQ-022 LOOKUP: hit = M & V, sampled in this cycle only. Transitions by condition:
- read hit -> RESP
- WRITE_BACK=0, write hit -> CWRITE
- WRITE_BACK=0, write miss -> MEM_REQ
- WRITE_BACK=1, write hit -> CWRITE
- WRITE_BACK=1, any miss with V&D=1 -> WB_REQ
- all other misses -> FILL_REQ
REQ-023 CWRITE: W=1, WSel=0.
- WRITE_BACK=1: DSet=1, next state RESP.
- WRITE_BACK=0: next state MEM_REQ.
REQ-024 MEM_REQ: MStrobe=1, MRW=1, WordIdx=0; load the latency counter with MEM_LAT-1; next state MEM_WAIT.
REQ-025 MEM_WAIT: MRW=1; decrement the counter each cycle; go to RESP in the cycle the counter equals 0, so MEM_WAIT lasts exactly MEM_LAT cycles.
REQ-026 WB_REQ / WB_WAIT: same as MEM_REQ / MEM_WAIT, with WordIdx = word counter. On counter 0:
- word counter < LINE_WORDS-1: increment it, go to WB_REQ.
- otherwise: clear it, go to FILL_REQ.
REQ-027 FILL_REQ / FILL_WAIT: same timing with MRW=0, WordIdx = word counter; on counter 0, go to FILL_WR.
REQ-028 FILL_WR: W=1, WSel=1, WordIdx = word counter. Then:
- word counter < LINE_WORDS-1: increment it, go to FILL_REQ.
- last word, read op: go to RESP; DClr=1 this cycle when WRITE_BACK=1.
- last word, write op: go to CWRITE.
REQ-029 RESP: Rdy=1 for one cycle, then IDLE. A Strobe in the RESP cycle is ignored; a Strobe in the following IDLE cycle is accepted.
REQ-030 Latency, with the Strobe-accept cycle = 0:
- read hit: Rdy at cycle 2.
- clean read miss: Rdy at cycle 2 + LINE_WORDS*(MEM_LAT+2).
- WRITE_BACK=0 write hit: Rdy at cycle MEM_LAT+4.
- WRITE_BACK=0 write miss: Rdy at cycle MEM_LAT+3.
- WRITE_BACK=1 dirty miss: adds LINE_WORDS*(MEM_LAT+1) cycles to the clean-miss latency.
REQ-031 Word counter is WIDX_W bits, cleared in IDLE. With LINE_WORDS=1 it stays 0 and exactly one word is transferred.
REQ-032 Exactly one MStrobe pulse per word transferred; MStrobe never high in two consecutive cycles.

Reset
REQ-033 reset=1 at a clock edge forces IDLE and clears the latency counter, word counter and operation register, regardless of current state.
REQ-034 During and after reset, until the next accepted Strobe, all outputs are 0, including WordIdx and Busy.
REQ-035 Reset mid-transfer aborts the transfer with no further MStrobe or W pulses and no Rdy.

Structure
REQ-036 Package cache_ctrl_pkg holds the state_t enumeration and the RW encoding constants (OP_READ=0, OP_WRITE=1).
REQ-037 Sub-module mem_lat_counter: a loadable down-counter with a done output, instantiated once.

Verification
REQ-038 Defaults; read with M=1, V=1 -> Rdy at cycle 2, no MStrobe.
REQ-039 Defaults; read with V=0 -> 4 MStrobe pulses with MRW=0 and WordIdx 0,1,2,3; 4 W pulses with WSel=1; Rdy at cycle 26.
REQ-040 Defaults; write hit -> W at cycle 2, MStrobe with MRW=1 at cycle 3, Rdy at cycle 8.
REQ-041 WRITE_BACK=1, LINE_WORDS=2, MEM_LAT=1; read miss with V=1, D=1 -> 2 write MStrobes, then 2 read MStrobes, DClr on the last FILL_WR, Rdy at cycle 12.
REQ-042 Defaults; reset asserted at cycle 5 of a miss -> IDLE next cycle, outputs 0, no Rdy.
REQ-043 Strobe held high continuously -> a new request is accepted only in an IDLE cycle, and Busy=0 only in those cycles.
